regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between the ALU (req0)
// and the load unit (req1); the winning write is registered onto the port one cycle later.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_din,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_din,
    output logic              req1_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] din,
    output logic              wb_src,
    output logic              starve
);

    logic              last_grant_q, last_grant_d;
    logic [2:0]        wait0_q, wait0_d, wait1_q, wait1_d;
    logic              wen_q, src_q, starve_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] din_q;

    logic              grant0, grant1, accept, sel;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_din;

    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        accept       = 1'b0;
        sel          = 1'b0;
        sel_rd       = req0_rd;
        sel_din      = req0_din;
        last_grant_d = last_grant_q;
        wait0_d      = 3'd0;
        wait1_d      = 3'd0;

        // On contention the requester that did not win last time gets the port.
        if (!rst && !flush) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end

        accept = grant0 || grant1;
        sel    = grant1;
        if (sel) begin
            sel_rd  = req1_rd;
            sel_din = req1_din;
        end
        if (accept) begin
            last_grant_d = sel;
        end

        if (!flush && req0_valid && !grant0) begin
            wait0_d = (wait0_q == 3'd7) ? 3'd7 : wait0_q + 3'd1;
        end
        if (!flush && req1_valid && !grant1) begin
            wait1_d = (wait1_q == 3'd7) ? 3'd7 : wait1_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wait0_q      <= 3'd0;
            wait1_q      <= 3'd0;
            wen_q        <= 1'b0;
            src_q        <= 1'b0;
            starve_q     <= 1'b0;
            rd_q         <= '0;
            din_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wait0_q      <= wait0_d;
            wait1_q      <= wait1_d;
            starve_q     <= (wait0_d >= 3'd4) || (wait1_d >= 3'd4);
            // Writes to x0 are still accepted and presented, but never enabled.
            wen_q        <= accept && (sel_rd != '0);
            if (accept) begin
                src_q <= sel;
                rd_q  <= sel_rd;
                din_q <= sel_din;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign wen        = wen_q;
    assign rd         = rd_q;
    assign din        = din_q;
    assign wb_src     = src_q;
    assign starve     = starve_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge, readies are
// checked before the rising edge and registered outputs 1ns after it.
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_rd = '0;
    logic [DATA_W-1:0] req0_din = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_rd = '0;
    logic [DATA_W-1:0] req1_din = '0;
    logic              req1_ready;
    logic              wen;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] din;
    logic              wb_src;
    logic              starve;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_din   (req0_din),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_din   (req1_din),
        .req1_ready (req1_ready),
        .wen        (wen),
        .rd         (rd),
        .din        (din),
        .wb_src     (wb_src),
        .starve     (starve)
    );

    always #5 clk = ~clk;

    task automatic set_reqs(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                            input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1);
        req0_valid = v0; req0_rd = r0; req0_din = d0;
        req1_valid = v1; req1_rd = r1; req1_din = d1;
    endtask

    task automatic test_reset();
        set_reqs(1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 32'h2);
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        checks++; if ({wen, wb_src, starve} !== 3'b000) begin errors++;
            $display("FAIL reset_flags: got %b want 000", {wen, wb_src, starve}); end
        checks++; if (rd !== 5'd0 || din !== 32'd0) begin errors++;
            $display("FAIL reset_data: got rd=%0d din=%h want 0/0", rd, din); end
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_contention();
        logic g;
        set_reqs(1'b1, 5'd2, 32'hA0A0_0000, 1'b1, 5'd3, 32'hB1B1_0000);
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 1);
            #1;
            checks++; if (req0_ready !== !g || req1_ready !== g) begin errors++;
                $display("FAIL contention_ready[%0d]: got %b%b want %b%b", i, req0_ready,
                         req1_ready, !g, g); end
            @(posedge clk); #1;
            checks++; if (wen !== 1'b1 || wb_src !== g || rd !== (g ? 5'd3 : 5'd2)) begin errors++;
                $display("FAIL contention_wb[%0d]: got wen=%b src=%b rd=%0d want 1/%b/%0d", i, wen,
                         wb_src, rd, g, g ? 3 : 2); end
            checks++; if (starve !== 1'b0) begin errors++;
                $display("FAIL contention_starve[%0d]: got %b want 0", i, starve); end
            @(negedge clk);
        end
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checks++; if (wen !== 1'b0 || rd !== 5'd3 || wb_src !== 1'b1) begin errors++;
            $display("FAIL idle_hold: got wen=%b rd=%0d src=%b want 0/3/1", wen, rd, wb_src); end
        @(negedge clk);
    endtask

    task automatic test_single();
        set_reqs(1'b1, 5'd10, 32'hBABE_FACE, 1'b0, '0, '0);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || rd !== 5'd10 || din !== 32'hBABE_FACE || wb_src !== 1'b0) begin
            errors++; $display("FAIL single_wb: got wen=%b rd=%0d din=%h src=%b want 1/10/babeface/0",
                               wen, rd, din, wb_src); end
        @(negedge clk);
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checks++; if (wen !== 1'b0 || din !== 32'hBABE_FACE) begin errors++;
            $display("FAIL single_hold: got wen=%b din=%h want 0/babeface", wen, din); end
        @(negedge clk);
    endtask

    task automatic test_x0();
        set_reqs(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++;
            $display("FAIL x0_ready: got %b want 1", req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b0 || rd !== 5'd0 || wb_src !== 1'b1 || din !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL x0_wb: got wen=%b rd=%0d src=%b din=%h want 0/0/1/ffffffff",
                               wen, rd, wb_src, din); end
        @(negedge clk);
        set_reqs(1'b1, 5'd8, 32'h8, 1'b1, 5'd9, 32'h9);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL x0_next_grant: got %b%b want 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || rd !== 5'd8 || wb_src !== 1'b0) begin errors++;
            $display("FAIL x0_next_wb: got wen=%b rd=%0d src=%b want 1/8/0", wen, rd, wb_src); end
        @(negedge clk);
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_flush();
        // last grant was req0, so req1 must win once the flush clears
        set_reqs(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD);
        flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++;
                $display("FAIL flush_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready); end
            @(posedge clk); #1;
            checks++; if (wen !== 1'b0 || starve !== 1'b0) begin errors++;
                $display("FAIL flush_wen[%0d]: got wen=%b starve=%b want 0/0", i, wen, starve); end
            @(negedge clk);
        end
        flush = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++;
            $display("FAIL flush_resume: got %b%b want 01", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || rd !== 5'd13 || wb_src !== 1'b1) begin errors++;
            $display("FAIL flush_resume_wb: got wen=%b rd=%0d src=%b want 1/13/1", wen, rd, wb_src); end
        @(negedge clk);
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_same_rd();
        set_reqs(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || rd !== 5'd7 || din !== 32'h1 || wb_src !== 1'b0) begin errors++;
            $display("FAIL same_rd_first: got wen=%b rd=%0d din=%h src=%b want 1/7/1/0", wen, rd, din,
                     wb_src); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++;
            $display("FAIL same_rd_ready: got %b want 1", req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || rd !== 5'd7 || din !== 32'h2 || wb_src !== 1'b1) begin errors++;
            $display("FAIL same_rd_second: got wen=%b rd=%0d din=%h src=%b want 1/7/2/1", wen, rd,
                     din, wb_src); end
        @(negedge clk);
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_async_reset();
        // req0 wins here, so without a reset the next contention would go to req1
        set_reqs(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (wen !== 1'b0 || rd !== 5'd0 || din !== 32'd0) begin errors++;
            $display("FAIL async_reset_now: got wen=%b rd=%0d din=%h want 0/0/0", wen, rd, din); end
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (wen !== 1'b0 || rd !== 5'd0) begin errors++;
            $display("FAIL async_reset_nowrite: got wen=%b rd=%0d want 0/0", wen, rd); end
        @(negedge clk);
        set_reqs(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL async_reset_grant: got %b%b want 10", req0_ready, req1_ready); end
        @(posedge clk); #1;
        checks++; if (wen !== 1'b1 || din !== 32'h22 || wb_src !== 1'b0) begin errors++;
            $display("FAIL async_reset_wb: got wen=%b din=%h src=%b want 1/22/0", wen, din, wb_src); end
        @(negedge clk);
        set_reqs(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_x0();
        test_flush();
        test_same_rd();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
